ks_i2s_out: RTL and testbench

- Downstream output stage for the Karplus-Strong voice.
- Captures the voice's 16-bit sample on each rising edge of the clk-synchronous clk_sample strobe and applies a 3-bit attenuation.
- Serializes the sample as mono-duplicated stereo I2S (bclk, lrclk, sdata) toward the board codec.
- Double-buffered (hold register plus frame shift register) with underrun/overrun status.

---
 rtl/ks_i2s_out.sv | 145 ++++++++++++++
 tb/tb_ks_i2s_out.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ks_i2s_out.sv
// Karplus-Strong output stage: captures/attenuates voice samples, serializes mono-duplicated I2S.
// Latency: capture visible in hold 1 clk after strobe; no backpressure, late samples overwritten and flagged.
module ks_i2s_out #(
    parameter int DATA_W   = 16,
    parameter int BCLK_DIV = 4
) (
    input  logic              clk,
    input  logic              aclr,
    input  logic              en,
    input  logic              clk_sample,
    input  logic [DATA_W-1:0] sample,
    input  logic [2:0]        atten,
    input  logic              clear_status,
    output logic              bclk,
    output logic              lrclk,
    output logic              sdata,
    output logic              frame_start,
    output logic              underrun,
    output logic              overrun
);
    localparam int DIV_W   = $clog2(BCLK_DIV);
    localparam int FRAME_W = 2 * DATA_W;
    localparam int BIT_W   = $clog2(FRAME_W);

    logic               cs_dly_q, cs_dly_d;
    logic               en_q, en_d;
    logic [DATA_W-1:0]  hold_q, hold_d;
    logic [FRAME_W-1:0] shift_q, shift_d;
    logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
    logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [1:0]         cap_cnt_q, cap_cnt_d;
    logic               bclk_q, bclk_d;
    logic               lrclk_q, lrclk_d;
    logic               sdata_q, sdata_d;
    logic               frame_start_q, frame_start_d;
    logic               underrun_q, underrun_d;
    logic               overrun_q, overrun_d;

    logic signed [DATA_W-1:0] sample_s;
    logic signed [DATA_W-1:0] shifted;
    logic                     rise, en_rise, fall, load;
    logic [DIV_W-1:0]         div_base;
    logic [BIT_W-1:0]         bit_base;
    logic                     bclk_base;

    assign sample_s = sample;

    always_comb begin
        rise      = clk_sample & ~cs_dly_q;
        en_rise   = en & ~en_q;
        cs_dly_d  = clk_sample;
        en_d      = en;
        shifted   = sample_s >>> atten;
        hold_d    = rise ? shifted : hold_q;

        // A fresh enable behaves exactly like coming out of reset.
        div_base  = en_rise ? '0 : div_cnt_q;
        bit_base  = en_rise ? '0 : bit_cnt_q;
        bclk_base = en_rise ? 1'b0 : bclk_q;

        div_cnt_d     = div_cnt_q;
        bit_cnt_d     = bit_cnt_q;
        bclk_d        = 1'b0;
        sdata_d       = 1'b0;
        lrclk_d       = lrclk_q;
        shift_d       = shift_q;
        frame_start_d = 1'b0;
        fall          = 1'b0;
        load          = 1'b0;

        if (en) begin
            bclk_d    = bclk_base;
            sdata_d   = sdata_q;
            bit_cnt_d = bit_base;
            div_cnt_d = div_base + DIV_W'(1);
            if (div_base == DIV_W'(BCLK_DIV - 1)) begin
                div_cnt_d = '0;
                bclk_d    = ~bclk_base;
                fall      = bclk_base;
            end
            if (fall) begin
                bit_cnt_d = (bit_base == BIT_W'(FRAME_W - 1)) ? '0 : bit_base + BIT_W'(1);
                lrclk_d   = (bit_cnt_d >= BIT_W'(DATA_W));
                load      = (bit_cnt_d == BIT_W'(1));
                if (load) begin
                    shift_d       = {hold_q, hold_q};
                    sdata_d       = hold_q[DATA_W-1];
                    frame_start_d = 1'b1;
                end else begin
                    shift_d = shift_q << 1;
                    sdata_d = shift_q[FRAME_W-2];
                end
            end
        end

        // A capture on the load edge belongs to the next frame.
        cap_cnt_d = cap_cnt_q;
        if (load)
            cap_cnt_d = rise ? 2'd1 : 2'd0;
        else if (rise && cap_cnt_q != 2'd3)
            cap_cnt_d = cap_cnt_q + 2'd1;

        underrun_d = (underrun_q & ~clear_status) | (load & (cap_cnt_q == 2'd0));
        overrun_d  = (overrun_q  & ~clear_status) | (load & (cap_cnt_q >= 2'd2));
    end

    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            cs_dly_q      <= 1'b0;
            en_q          <= 1'b0;
            hold_q        <= '0;
            shift_q       <= '0;
            div_cnt_q     <= '0;
            bit_cnt_q     <= '0;
            cap_cnt_q     <= '0;
            bclk_q        <= 1'b0;
            lrclk_q       <= 1'b0;
            sdata_q       <= 1'b0;
            frame_start_q <= 1'b0;
            underrun_q    <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            cs_dly_q      <= cs_dly_d;
            en_q          <= en_d;
            hold_q        <= hold_d;
            shift_q       <= shift_d;
            div_cnt_q     <= div_cnt_d;
            bit_cnt_q     <= bit_cnt_d;
            cap_cnt_q     <= cap_cnt_d;
            bclk_q        <= bclk_d;
            lrclk_q       <= lrclk_d;
            sdata_q       <= sdata_d;
            frame_start_q <= frame_start_d;
            underrun_q    <= underrun_d;
            overrun_q     <= overrun_d;
        end
    end

    assign bclk        = bclk_q;
    assign lrclk       = lrclk_q;
    assign sdata       = sdata_q;
    assign frame_start = frame_start_q;
    assign underrun    = underrun_q;
    assign overrun     = overrun_q;
endmodule

// File: tb/tb_ks_i2s_out.sv
// Directed + randomized bench for ks_i2s_out; expected frames come from an arithmetic attenuation model.
module tb_ks_i2s_out;
    logic        clk = 1'b0;
    logic        aclr, en, clk_sample, clear_status;
    logic [15:0] sample;
    logic [2:0]  atten;
    logic        bclk, lrclk, sdata, frame_start, underrun, overrun;

    int checks   = 0;
    int failures = 0;
    logic any_tmo = 1'b0;

    ks_i2s_out #(.DATA_W(16), .BCLK_DIV(4)) dut (
        .clk(clk), .aclr(aclr), .en(en), .clk_sample(clk_sample),
        .sample(sample), .atten(atten), .clear_status(clear_status),
        .bclk(bclk), .lrclk(lrclk), .sdata(sdata), .frame_start(frame_start),
        .underrun(underrun), .overrun(overrun)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed=running required=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Attenuation as floor division by 2^a on the signed sample value.
    function automatic logic [15:0] exp_hold(input logic [15:0] s, input logic [2:0] a);
        int sv, d, q;
        sv = int'($signed(s));
        d  = 1 << a;
        if (sv >= 0) q = sv / d;
        else         q = -((-sv + d - 1) / d);
        return q[15:0];
    endfunction

    task automatic wait_fs(output int n);
        n = 0;
        while (n < 400) begin
            @(negedge clk);
            n++;
            if (frame_start) break;
        end
        chk("fs_seen", frame_start, 1);
    endtask

    task automatic wait_fall();
        logic pb;
        int   w;
        logic tmo;
        pb  = bclk;
        w   = 0;
        tmo = 1'b1;
        while (w < 40) begin
            @(negedge clk);
            w++;
            if (pb && !bclk) begin
                tmo = 1'b0;
                break;
            end
            pb = bclk;
        end
        if (tmo) any_tmo = 1'b1;
    endtask

    task automatic get_frame(output logic [31:0] bits, output logic [31:0] lr,
                             output int n, output logic uf, output logic of);
        wait_fs(n);
        uf = underrun;
        of = overrun;
        bits = '0;
        lr   = '0;
        bits[31] = sdata;
        lr[31]   = lrclk;
        for (int k = 1; k < 32; k++) begin
            wait_fall();
            bits[31-k] = sdata;
            lr[31-k]   = lrclk;
        end
        chk("frame_tmo", any_tmo, 0);
    endtask

    task automatic measure(input logic use_lr, output int p);
        logic prv, cur;
        int   w;
        prv = use_lr ? lrclk : bclk;
        cur = prv;
        w   = 0;
        while (w < 300) begin
            @(negedge clk);
            w++;
            cur = use_lr ? lrclk : bclk;
            if (use_lr ? (cur != prv) : (cur && !prv)) break;
            prv = cur;
        end
        prv = cur;
        p   = 0;
        while (p < 300) begin
            @(negedge clk);
            p++;
            cur = use_lr ? lrclk : bclk;
            if (use_lr ? (cur != prv) : (cur && !prv)) break;
            prv = cur;
        end
        if (p >= 300) p = -1;
    endtask

    task automatic pulse(input logic [15:0] s, input logic [2:0] a);
        sample     = s;
        atten      = a;
        clk_sample = 1'b1;
        @(negedge clk);
        clk_sample = 1'b0;
    endtask

    initial begin
        logic [31:0] bits, lr, exp_lr;
        int          n;
        logic        uf, of;
        logic [15:0] hm, rs;
        logic [2:0]  ra;

        // Word select is high while the bit counter sits in the right half (16..31).
        for (int k = 0; k < 32; k++) exp_lr[31-k] = (((k + 1) % 32) >= 16);

        aclr = 1'b1; en = 1'b1; clk_sample = 1'b0; sample = '0; atten = '0; clear_status = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outs", {26'd0, bclk, lrclk, sdata, frame_start, underrun, overrun}, 0);
        aclr = 1'b0;

        wait_fs(n);
        chk("first_fs_lat", n, 8);
        chk("underrun_first", underrun, 1);
        measure(1'b0, n);
        chk("bclk_period", n, 8);
        measure(1'b1, n);
        chk("lrclk_half", n, 128);

        // Single capture, flags cleared in the same frame.
        wait_fs(n);
        clear_status = 1'b1;
        hm = exp_hold(16'h8001, 3'd0);
        pulse(16'h8001, 3'd0);
        clear_status = 1'b0;
        chk("underrun_cleared", underrun, 0);
        get_frame(bits, lr, n, uf, of);
        chk("frame_8001", bits, {hm, hm});
        chk("lr_pattern", lr, exp_lr);
        chk("flags_one_cap", {30'd0, uf, of}, 0);

        wait_fs(n);
        hm = exp_hold(16'hF000, 3'd3);
        pulse(16'hF000, 3'd3);
        get_frame(bits, lr, n, uf, of);
        chk("atten_f000_3", bits, {hm, hm});

        wait_fs(n);
        hm = exp_hold(16'h7FFF, 3'd7);
        pulse(16'h7FFF, 3'd7);
        get_frame(bits, lr, n, uf, of);
        chk("atten_7fff_7", bits, {hm, hm});

        // Three captures in one frame; the last one is what gets sent.
        wait_fs(n);
        pulse(16'h1234, 3'd0);
        @(negedge clk);
        pulse(16'h5678, 3'd1);
        @(negedge clk);
        rs = 16'($urandom);
        hm = exp_hold(rs, 3'd2);
        pulse(rs, 3'd2);
        get_frame(bits, lr, n, uf, of);
        chk("overrun_set", of, 1);
        chk("overrun_frame", bits, {hm, hm});

        // clear_status on the very load edge of an underrun frame.
        wait_fs(n);
        clear_status = 1'b1;
        @(negedge clk);
        clear_status = 1'b0;
        chk("flags_cleared", {30'd0, underrun, overrun}, 0);
        repeat (254) @(negedge clk);
        clear_status = 1'b1;
        @(negedge clk);
        clear_status = 1'b0;
        chk("load_at_256", frame_start, 1);
        chk("underrun_wins", underrun, 1);
        chk("overrun_clear", overrun, 0);

        // Disable at bit 9, capture while disabled, then re-enable.
        repeat (8) wait_fall();
        en = 1'b0;
        @(negedge clk);
        chk("dis_outs", {30'd0, bclk, sdata}, 0);
        chk("dis_lr", lrclk, 0);
        hm = exp_hold(16'hA5C3, 3'd1);
        pulse(16'hA5C3, 3'd1);
        repeat (10) @(negedge clk);
        chk("dis_hold", {29'd0, bclk, lrclk, sdata}, 0);
        en = 1'b1;
        get_frame(bits, lr, n, uf, of);
        chk("reen_lat", n, 8);
        chk("reen_frame", bits, {hm, hm});

        // Asynchronous reset in the right slot.
        wait_fs(n);
        repeat (20) wait_fall();
        chk("pre_rst_lr", {30'd0, lrclk, underrun}, 3);
        aclr = 1'b1;
        #1;
        chk("async_rst", {26'd0, bclk, lrclk, sdata, frame_start, underrun, overrun}, 0);
        @(negedge clk);
        aclr = 1'b0;
        wait_fs(n);
        chk("post_rst_lat", n, 8);
        rs = 16'($urandom);
        ra = 3'($urandom_range(0, 7));
        hm = exp_hold(rs, ra);
        pulse(rs, ra);
        get_frame(bits, lr, n, uf, of);
        chk("post_rst_frame", bits, {hm, hm});
        chk("post_rst_lr", lr, exp_lr);

        for (int i = 0; i < 4; i++) begin
            wait_fs(n);
            rs = 16'($urandom);
            ra = 3'($urandom_range(0, 7));
            hm = exp_hold(rs, ra);
            pulse(rs, ra);
            get_frame(bits, lr, n, uf, of);
            chk("rand_frame", bits, {hm, hm});
            chk("rand_no_ovr", of, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
